alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu32.sv | 34 +++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op-code constants, arbiter FSM encoding and the latched operation payload.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SLL = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR = 3'b100;
    localparam logic [OP_W-1:0] OP_BAD = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              id;
    } op_req_t;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; op 101 is unsupported and flags an error with a zero result.
module alu32
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result_c,
    output logic              zero_c,
    output logic              err_c
);

    logic [DATA_W-1:0] diff_c;

    always_comb begin
        diff_c   = a - b;
        result_c = '0;
        err_c    = 1'b0;
        case (op)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = diff_c;
            // slt is the sign bit of the modulo difference
            OP_SLT:  result_c = DATA_W'(diff_c[DATA_W-1]);
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_NOR:  result_c = ~(a | b);
            // full-width shift amount, so a >= 32 clears the result
            OP_SLL:  result_c = b << a;
            default: err_c    = 1'b1;
        endcase
        zero_c = !err_c && (result_c == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing a single alu32; one operation in flight
// at a time (accept -> execute -> respond).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_e            state_q;
    state_e            state_d;
    logic              last_q;
    logic              gnt_c;
    logic              any_valid_c;
    logic              accept_c;
    op_req_t           op_q;
    op_req_t           req_sel_c;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_zero_c;
    logic              alu_err_c;

    // Round-robin pick: contention goes to whoever was not granted last.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        gnt_c       = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_c = ~last_q;
        end
        req_sel_c = gnt_c ? '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1}
                          : '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
    end

    // Ready is offered only in IDLE and is held low while reset is asserted.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_c && rst_n) begin
                    accept_c   = 1'b1;
                    req0_ready = ~gnt_c;
                    req1_ready = gnt_c;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= ~RST_PRIO;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                op_q   <= req_sel_c;
                last_q <= gnt_c;
            end
        end
    end

    alu32 u_alu (
        .a        (op_q.a),
        .b        (op_q.b),
        .op       (op_q.op),
        .result_c (alu_result_c),
        .zero_c   (alu_zero_c),
        .err_c    (alu_err_c)
    );

    // Response registers load at the end of EXEC and clear on handoff, so they read 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= op_q.id;
            rsp_result <= alu_result_c;
            rsp_zero   <= alu_zero_c;
            rsp_err    <= alu_err_c;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses queued at grant, checked at handoff.
module tb_alu_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.RST_PRIO(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    function automatic exp_t mk(input logic id, input logic [31:0] r, input logic z, input logic e);
        exp_t x;
        x = {id, r, z, e};
        return x;
    endfunction

    function automatic exp_t model(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] d;
        logic        e;
        r = 32'd0;
        e = 1'b0;
        d = a - b;
        case (op)
            3'b010:  r = a + b;
            3'b110:  r = d;
            3'b111:  r = {31'd0, d[31]};
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b100:  r = ~(a | b);
            3'b011:  r = (a > 32'd31) ? 32'd0 : (b << a[4:0]);
            default: e = 1'b1;
        endcase
        return mk(id, r, !e && (r == 32'd0), e);
    endfunction

    task automatic drive(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Deasserts valid and scrambles the operands, which must then be ignored.
    task automatic drop(input int r);
        if (r == 0) begin
            req0_valid = 1'b0; req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom;
        end else begin
            req1_valid = 1'b0; req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom;
        end
    endtask

    task automatic wait_ready(input int r, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (r == 0) ? req0_ready : req1_ready;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            done = (sb.size() == 0) && !rsp_valid;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain: pending=%0d rsp_valid=%b required pending=0 rsp_valid=0", sb.size(), rsp_valid);
        end
    endtask

    task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        bit got;
        @(posedge clk); #1 drive(r, op, a, b);
        wait_ready(r, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL issue_ready: req%0d never granted, required grant", r);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1 drop(r);
    endtask

    // Scoreboard: pop on every handoff; outputs must be zero whenever rsp_valid is low.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: id=%0d result=%h, required no response", rsp_id, rsp_result);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== e) begin
                    failures++;
                    $display("FAIL rsp_data: got id=%0d result=%h zero=%b err=%b, required id=%0d result=%h zero=%b err=%b",
                             rsp_id, rsp_result, rsp_zero, rsp_err, e.id, e.result, e.zero, e.err);
                end
            end
        end else if (!rsp_valid) begin
            checks++;
            if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== 35'd0) begin
                failures++;
                $display("FAIL rsp_idle_zero: got id=%0d result=%h zero=%b err=%b, required all 0",
                         rsp_id, rsp_result, rsp_zero, rsp_err);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive(0, 3'b010, 32'd1, 32'd1);
        drive(1, 3'b010, 32'd1, 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== 37'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b%b rsp_valid=%b id=%b result=%h zero=%b err=%b, required all 0",
                     req1_ready, req0_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        drop(0);
        drop(1);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Starts in the cycle reset is released: the first rising edge must accept.
    task automatic test_latency();
        drive(0, 3'b010, 32'd5, 32'd7);
        sb.push_back(mk(1'b0, 32'd12, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL lat_grant: ready=%b%b required 01", req1_ready, req0_ready);
        end
        @(posedge clk); #1 drop(0);
        drive(1, 3'b001, 32'd3, 32'd5);
        @(negedge clk);
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL lat_exec: rsp_valid=%b ready1=%b required 0 0", rsp_valid, req1_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL lat_resp: rsp_valid=%b ready1=%b required 1 0", rsp_valid, req1_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL lat_ii: rsp_valid=%b ready1=%b required 0 1", rsp_valid, req1_ready);
        end
        sb.push_back(mk(1'b1, 32'd7, 1'b0, 1'b0));
        @(posedge clk); #1 drop(1);
        drain();
    endtask

    task automatic test_contention();
        bit got;
        reset_dut();
        drive(0, 3'b110, 32'd9, 32'd9);
        drive(1, 3'b111, 32'hFFFF_FFFD, 32'd2);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL contend_first: ready=%b%b required 01", req1_ready, req0_ready);
        end
        sb.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0));
        sb.push_back(mk(1'b1, 32'd1, 1'b0, 1'b0));
        @(posedge clk); #1 drop(0);
        wait_ready(1, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL contend_second: req1 never granted, required grant");
        end
        @(posedge clk); #1 drop(1);
        drain();
    endtask

    task automatic test_round_robin();
        logic [31:0] a_s[2];
        logic [31:0] b_s[2];
        logic [2:0]  op_s[2];
        bit          got;
        logic [1:0]  want;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            a_s[r] = $urandom; b_s[r] = $urandom; op_s[r] = 3'($urandom);
            drive(r, op_s[r], a_s[r], b_s[r]);
        end
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 2;
            want = (g == 0) ? 2'b01 : 2'b10;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = req0_ready | req1_ready;
            end
            checks++;
            if ({req1_ready, req0_ready} !== want) begin
                failures++;
                $display("FAIL rr_grant%0d: ready=%b%b required %b", k, req1_ready, req0_ready, want);
            end
            sb.push_back(model(g[0], op_s[g], a_s[g], b_s[g]));
            @(posedge clk); #1;
            a_s[g] = $urandom; b_s[g] = $urandom; op_s[g] = 3'($urandom);
            drive(g, op_s[g], a_s[g], b_s[g]);
        end
        drop(0);
        drop(1);
        drain();
    endtask

    task automatic test_backpressure();
        bit   got;
        exp_t held;
        held = mk(1'b0, 32'hF000_1200, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        @(posedge clk); #1 drive(0, 3'b000, 32'hF0F0_1234, 32'hFF00_FF00);
        wait_ready(0, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_grant: req0 never granted, required grant");
        end
        sb.push_back(held);
        @(posedge clk); #1;
        drive(0, 3'b110, 32'd1, 32'd2);
        drive(1, 3'b100, 32'd0, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req0_ready, req1_ready} !== {1'b1, held, 2'b00}) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b id=%b result=%h zero=%b err=%b ready=%b%b, required 1 0 f0001200 0 0 00",
                         c, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req1_ready, req0_ready);
            end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        sb.push_back(mk(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0));
        sb.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        wait_ready(1, got);
        checks++;
        if (!got || req0_ready) begin
            failures++;
            $display("FAIL bp_after1: ready=%b%b required 10", req1_ready, req0_ready);
        end
        @(posedge clk); #1 drop(1);
        wait_ready(0, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_after0: req0 never granted, required grant");
        end
        @(posedge clk); #1 drop(0);
        drain();
    endtask

    task automatic test_reset_exec();
        bit got;
        @(posedge clk); #1 drive(0, 3'b010, 32'd100, 32'd23);
        wait_ready(0, got);
        @(posedge clk); #1 drop(0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            failures++;
            $display("FAIL rst_exec_now: rsp_valid=%b ready=%b%b required 0 00", rsp_valid, req1_ready, req0_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_exec_stale%0d: rsp_valid=%b required 0", c, rsp_valid);
            end
        end
        @(posedge clk); #1;
        drive(0, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        drive(1, 3'b010, 32'd1, 32'd2);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_exec_prio: ready=%b%b required 01", req1_ready, req0_ready);
        end
        sb.push_back(mk(1'b0, 32'h0000_00FF, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 32'd3, 1'b0, 1'b0));
        @(posedge clk); #1 drop(0);
        wait_ready(1, got);
        @(posedge clk); #1 drop(1);
        drain();
    endtask

    task automatic test_err_sll();
        issue(1, 3'b101, 32'h1234, 32'h5678, mk(1'b1, 32'd0, 1'b0, 1'b1));
        issue(1, 3'b011, 32'd4, 32'd1, mk(1'b1, 32'd16, 1'b0, 1'b0));
        issue(0, 3'b011, 32'd32, 32'd1, mk(1'b0, 32'd0, 1'b1, 1'b0));
        issue(1, 3'b011, 32'd31, 32'd1, mk(1'b1, 32'h8000_0000, 1'b0, 1'b0));
        issue(0, 3'b010, 32'hFFFF_FFFF, 32'd1, mk(1'b0, 32'd0, 1'b1, 1'b0));
        issue(1, 3'b111, 32'd5, 32'd3, mk(1'b1, 32'd0, 1'b1, 1'b0));
        issue(0, 3'b100, 32'd0, 32'd0, mk(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0));
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            int          r;
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            r  = int'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b  = $urandom;
            issue(r, op, a, b, model(r[0], op, a, b));
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = '0; req1_op = '0;
        test_reset();
        test_latency();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_err_sll();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
